io_port_bank: RTL and testbench

IO_PORT_BANK -- requirements
Module: io_port_bank

---
 rtl/io_port_bank.sv | 235 +++++++++++++++++++++++
 tb/tb_io_port_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
// io_port_bank -- CPU I/O port bank.
//
// Inport path: words from an external device are pushed into a small
// first-word-fall-through queue that the CPU pops with IN. Outport path:
// NUM_OUT independent channels, each a two-state EMPTY/PENDING holding
// register loaded by OUT and released by the device's acknowledge.
//
// Build option:
//   IOPORT_FIFO_EN  defined   -> inport queue is FIFO_DEPTH entries deep.
//                   undefined -> inport is a single holding register (depth 1)
//                                with the same ports and push/pop/overflow rules.
//
// Ports:
//   Clock              sole clock, rising edge
//   clear              asynchronous active-low reset
//   inport_data        word from the input device
//   inport_data_ready  push strobe
//   inport_full        queue holds its full capacity
//   in_read            CPU pop strobe
//   in_data_out        head word, 0 when empty
//   in_valid           queue not empty
//   in_count           words held
//   in_overflow        sticky: a pushed word was dropped
//   overflow_clr       clears in_overflow
//   bus_in             datapath value for OUT
//   outport_in         OUT write strobe
//   out_sel            OUT target channel
//   outport_data       channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   outport_valid      channel i holds unacknowledged data
//   outport_ack        device consumed channel i
module io_port_bank #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int NUM_OUT       = 2,
  parameter int OUT_SEL_WIDTH = 1
) (
  input  logic                          Clock,
  input  logic                          clear,
  input  logic [DATA_WIDTH-1:0]         inport_data,
  input  logic                          inport_data_ready,
  output logic                          inport_full,
  input  logic                          in_read,
  output logic [DATA_WIDTH-1:0]         in_data_out,
  output logic                          in_valid,
  output logic [$clog2(FIFO_DEPTH):0]   in_count,
  output logic                          in_overflow,
  input  logic                          overflow_clr,
  input  logic [DATA_WIDTH-1:0]         bus_in,
  input  logic                          outport_in,
  input  logic [OUT_SEL_WIDTH-1:0]      out_sel,
  output logic [NUM_OUT*DATA_WIDTH-1:0] outport_data,
  output logic [NUM_OUT-1:0]            outport_valid,
  input  logic [NUM_OUT-1:0]            outport_ack
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef IOPORT_FIFO_EN
  localparam int EFF_DEPTH = FIFO_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif
  // A depth-1 queue still gets a 1-bit pointer; it simply never leaves 0.
  localparam int PTR_W = (EFF_DEPTH > 1) ? $clog2(EFF_DEPTH) : 1;
  localparam int SLOTS = 1 << PTR_W;

  typedef enum logic {
    OUT_EMPTY   = 1'b0,
    OUT_PENDING = 1'b1
  } out_state_t;

  // Wrap a queue pointer modulo the effective depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(EFF_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // ---------------- inport queue ----------------
  logic [DATA_WIDTH-1:0] mem_r [SLOTS];
  logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic                  valid_r, full_r, ovf_r;

  logic                  pop_s, push_s, drop_s;
  logic [PTR_W-1:0]      rd_ptr_next_s, wr_ptr_next_s;
  logic [CNT_W-1:0]      count_next_s;
  logic [DATA_WIDTH-1:0] head_next_s;

  // Inport next-state: push/pop decisions, pointer/count update, next head word.
  always_comb begin
    pop_s         = in_read && valid_r;
    // A full queue still accepts a word when a pop frees a slot in the same cycle.
    push_s        = inport_data_ready && (!full_r || pop_s);
    drop_s        = inport_data_ready && full_r && !pop_s;
    rd_ptr_next_s = rd_ptr_r;
    wr_ptr_next_s = wr_ptr_r;
    count_next_s  = count_r;
    head_next_s   = {DATA_WIDTH{1'b0}};

    if (pop_s) begin
      rd_ptr_next_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    if (push_s) begin
      wr_ptr_next_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase

    // Head is registered, so when the new head is the word being written
    // this cycle it must be taken from the input rather than from storage.
    if (count_next_s == {CNT_W{1'b0}}) begin
      head_next_s = {DATA_WIDTH{1'b0}};
    end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
      head_next_s = inport_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Inport state registers and sticky overflow flag.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      head_r   <= {DATA_WIDTH{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= inport_data;
      end
      rd_ptr_r <= rd_ptr_next_s;
      wr_ptr_r <= wr_ptr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
      valid_r  <= (count_next_s != {CNT_W{1'b0}});
      full_r   <= (count_next_s == CNT_W'(EFF_DEPTH));
      // A new drop wins over a simultaneous clear request.
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (overflow_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign inport_full = full_r;
  assign in_data_out = head_r;
  assign in_valid    = valid_r;
  assign in_count    = count_r;
  assign in_overflow = ovf_r;

  // ---------------- outport channels ----------------
  out_state_t            state_r      [NUM_OUT];
  out_state_t            state_next_s [NUM_OUT];
  logic [DATA_WIDTH-1:0] data_r       [NUM_OUT];
  logic [DATA_WIDTH-1:0] data_next_s  [NUM_OUT];
  logic                  wr_hit_s     [NUM_OUT];

  // Per-channel EMPTY/PENDING next state; a write beats an ack on the same channel.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      // Selects at or above NUM_OUT match no channel and so change nothing.
      wr_hit_s[i]     = outport_in && (out_sel == OUT_SEL_WIDTH'(i));
      state_next_s[i] = state_r[i];
      data_next_s[i]  = data_r[i];
      case (state_r[i])
        OUT_EMPTY: begin
          if (wr_hit_s[i]) begin
            state_next_s[i] = OUT_PENDING;
            data_next_s[i]  = bus_in;
          end else begin
            state_next_s[i] = OUT_EMPTY;
          end
        end
        OUT_PENDING: begin
          if (wr_hit_s[i]) begin
            state_next_s[i] = OUT_PENDING;
            data_next_s[i]  = bus_in;
          end else if (outport_ack[i]) begin
            state_next_s[i] = OUT_EMPTY;
          end else begin
            state_next_s[i] = OUT_PENDING;
          end
        end
        default: begin
          state_next_s[i] = OUT_EMPTY;
        end
      endcase
    end
  end

  // Outport channel state and data registers.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        state_r[i] <= OUT_EMPTY;
        data_r[i]  <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        state_r[i] <= state_next_s[i];
        data_r[i]  <= data_next_s[i];
      end
    end
  end

  // Flatten channel registers onto the packed output buses.
  always_comb begin
    outport_data  = {(NUM_OUT*DATA_WIDTH){1'b0}};
    outport_valid = {NUM_OUT{1'b0}};
    for (int i = 0; i < NUM_OUT; i++) begin
      outport_data[i*DATA_WIDTH +: DATA_WIDTH] = data_r[i];
      outport_valid[i]                         = (state_r[i] == OUT_PENDING);
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed scenarios followed by random
// traffic, all compared against a queue/array reference model.
module tb_io_port_bank;

  localparam int DW = 32;
  localparam int FD = 4;
  localparam int NO = 2;
  localparam int SW = 2;
  localparam int CW = $clog2(FD) + 1;
`ifdef IOPORT_FIFO_EN
  localparam int CAP = FD;
`else
  localparam int CAP = 1;
`endif

  logic              Clock;
  logic              clear;
  logic [DW-1:0]     inport_data;
  logic              inport_data_ready;
  logic              inport_full;
  logic              in_read;
  logic [DW-1:0]     in_data_out;
  logic              in_valid;
  logic [CW-1:0]     in_count;
  logic              in_overflow;
  logic              overflow_clr;
  logic [DW-1:0]     bus_in;
  logic              outport_in;
  logic [SW-1:0]     out_sel;
  logic [NO*DW-1:0]  outport_data;
  logic [NO-1:0]     outport_valid;
  logic [NO-1:0]     outport_ack;

  io_port_bank #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .NUM_OUT(NO), .OUT_SEL_WIDTH(SW)
  ) dut (
    .Clock(Clock), .clear(clear),
    .inport_data(inport_data), .inport_data_ready(inport_data_ready),
    .inport_full(inport_full), .in_read(in_read), .in_data_out(in_data_out),
    .in_valid(in_valid), .in_count(in_count), .in_overflow(in_overflow),
    .overflow_clr(overflow_clr), .bus_in(bus_in), .outport_in(outport_in),
    .out_sel(out_sel), .outport_data(outport_data),
    .outport_valid(outport_valid), .outport_ack(outport_ack)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] q [$];
  logic          m_ovf;
  logic [DW-1:0] m_data  [NO];
  logic          m_valid [NO];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < NO; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    logic full, pop, push, drop;
    full = (q.size() == CAP);
    pop  = in_read && (q.size() > 0);
    push = inport_data_ready && (!full || pop);
    drop = inport_data_ready && full && !pop;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(inport_data);
    if (drop) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    for (int i = 0; i < NO; i++) begin
      if (outport_in && (int'(out_sel) == i)) begin
        m_data[i]  = bus_in;
        m_valid[i] = 1'b1;
      end else if (outport_ack[i]) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    logic [63:0] exp_od;
    logic [63:0] exp_ov;
    exp_od = '0;
    exp_ov = '0;
    for (int i = 0; i < NO; i++) begin
      exp_od[i*DW +: DW] = m_data[i];
      exp_ov[i]          = m_valid[i];
    end
    check({ctx, ".count"}, 64'(in_count), 64'(q.size()));
    check({ctx, ".valid"}, 64'(in_valid), 64'(q.size() > 0));
    check({ctx, ".full"},  64'(inport_full), 64'(q.size() == CAP));
    check({ctx, ".head"},  64'(in_data_out), (q.size() > 0) ? 64'(q[0]) : 64'd0);
    check({ctx, ".ovf"},   64'(in_overflow), 64'(m_ovf));
    check({ctx, ".odata"}, 64'(outport_data), exp_od);
    check({ctx, ".ovalid"}, 64'(outport_valid), exp_ov);
  endtask

  task automatic step(input string ctx);
    @(posedge Clock);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic drive(input string ctx, input logic rdy, input logic [DW-1:0] d,
                       input logic rd, input logic clr, input logic oin,
                       input logic [SW-1:0] sel, input logic [DW-1:0] bus,
                       input logic [NO-1:0] ack);
    inport_data_ready = rdy;
    inport_data       = d;
    in_read           = rd;
    overflow_clr      = clr;
    outport_in        = oin;
    out_sel           = sel;
    bus_in            = bus;
    outport_ack       = ack;
    step(ctx);
  endtask

  task automatic idle(input string ctx);
    drive(ctx, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
  endtask

  // Assert reset between edges and check that everything clears at once.
  task automatic async_reset(input string ctx);
    clear = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    #2;
    clear = 1'b1;
  endtask

  initial begin
    clear = 1'b0;
    inport_data = '0; inport_data_ready = 1'b0; in_read = 1'b0;
    overflow_clr = 1'b0; bus_in = '0; outport_in = 1'b0; out_sel = '0;
    outport_ack = '0;
    #1;
    model_reset();
    check_all("reset");
    #12;
    clear = 1'b1;

    // Three pushes then three pops.
    for (int i = 0; i < 3; i++) drive("push567", 1'b1, 32'h5 + 32'(i), 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
    idle("hold567");
    for (int i = 0; i < 3; i++) drive("pop567", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
    drive("pop_empty", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);

    // Overfill, then clear the sticky flag and drain.
    for (int i = 0; i < 5; i++) drive("overfill", 1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
    drive("ovf_clr", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 2'b00);
    drive("ovf_and_clr", 1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 2'b00);
    drive("ovf_clr2", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 2'b00);
    for (int i = 0; i < FD; i++) drive("drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);

    // Simultaneous push/pop on a full queue and on an empty queue.
    for (int i = 0; i < FD; i++) drive("fill", 1'b1, 32'h20 + 32'(i), 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
    drive("full_pushpop", 1'b1, 32'hAA, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
    for (int i = 0; i < FD; i++) drive("drain2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
    drive("empty_pushpop", 1'b1, 32'hBB, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
    drive("pop_bb", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);

    // Outport write, ack, write+ack, ack in EMPTY, out-of-range selects.
    drive("ow_ch1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd1, 32'hDEADBEEF, 2'b00);
    drive("ack_ch1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'b10);
    drive("ack_empty", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'b11);
    drive("ow_ack1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd1, 32'hCAFEF00D, 2'b10);
    drive("ow_ch0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h12345678, 2'b10);
    drive("ow_sel2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h55555555, 2'b00);
    drive("ow_sel3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h66666666, 2'b00);

    // Reset mid-burst with words queued and channels pending.
    for (int i = 0; i < 3; i++) drive("burst", 1'b1, 32'h30 + 32'(i), 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'b00);
    async_reset("mid_reset");
    idle("post_reset");

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_reset");
      end
      drive("rand",
            1'($urandom_range(0, 99) < 55), $urandom(),
            1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 10),
            1'($urandom_range(0, 99) < 40), 2'($urandom_range(0, 3)), $urandom(),
            2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
